// File: rtl/fpu_result_stage_pkg.sv
// fpu_result_stage_pkg: op codes, exception codes, special values and FSM states
// shared by the FPU result stage and its special-result helper.
package fpu_result_stage_pkg;

    localparam logic [1:0] _ADDITION       = 2'b00;
    localparam logic [1:0] _SUBTRACTION    = 2'b01;
    localparam logic [1:0] _MULTIPLICATION = 2'b10;
    localparam logic [1:0] _DIVISION       = 2'b11;

    localparam logic [2:0] _NO_EXCE       = 3'b000;
    localparam logic [2:0] _qNAN_EXCE     = 3'b001;
    localparam logic [2:0] _INF_EXCE      = 3'b010;
    localparam logic [2:0] _ZERO_DIV_EXCE = 3'b011;
    localparam logic [2:0] _CORE_TO_EXCE  = 3'b100;

    localparam logic [7:0] _QNAN      = 8'h7C;
    localparam logic [7:0] _PLUS_INF  = 8'h78;
    localparam logic [7:0] _MINUS_INF = 8'hF8;

    typedef enum logic [1:0] {_ST_IDLE, _ST_ISSUE, _ST_WAIT, _ST_HOLD} state_t;

    // Sticky layout {timeout, div_by_zero, invalid, nan_input}; unlisted codes set nothing.
    function automatic logic [3:0] sticky_flag(input logic [2:0] exce);
        return exce == _qNAN_EXCE     ? 4'b0001 :
               exce == _INF_EXCE      ? 4'b0010 :
               exce == _ZERO_DIV_EXCE ? 4'b0100 :
               exce == _CORE_TO_EXCE  ? 4'b1000 : 4'b0000;
    endfunction

endpackage

// File: rtl/fpu_special_result.sv
// fpu_special_result: maps an exception verdict and operands to the IEEE-style special result.
module fpu_special_result
    import fpu_result_stage_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic       i_b_sign,
    input  logic [2:0] i_exce,
    output logic [7:0] o_result
);

    // Only x/0 with a non-zero dividend yields a signed infinity; 0/0 and everything else is qNaN.
    always_comb begin
        o_result = (i_exce == _ZERO_DIV_EXCE && i_a[6:0] != 7'h00)
                 ? ((i_a[7] ^ i_b_sign) ? _MINUS_INF : _PLUS_INF)
                 : _QNAN;
    end

endmodule

// File: rtl/fpu_result_stage.sv
// fpu_result_stage: issues non-exceptional ops to the arithmetic core, substitutes special
// results for exceptions, presents one registered result and accumulates sticky flags.
module fpu_result_stage
    import fpu_result_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [1:0] FP_OPERATION,
    input  logic [7:0] OP_A,
    input  logic [7:0] OP_B,
    input  logic       OP_IS_EXCEPTION,
    input  logic [2:0] FP_EXCE,
    output logic       CORE_START,
    output logic [1:0] CORE_OP,
    output logic [7:0] CORE_A,
    output logic [7:0] CORE_B,
    input  logic       CORE_DONE,
    input  logic [7:0] CORE_RESULT,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [7:0] RESULT,
    output logic [2:0] RESULT_EXCE,
    output logic [3:0] STICKY_FLAGS,
    input  logic       STICKY_CLR
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_op;
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic [7:0]      r_result;
    logic [2:0]      r_exce;
    logic [3:0]      r_sticky;
    logic [7:0]      w_special;
    logic            w_timeout;
    logic            w_fire;

    fpu_special_result u_special (
        .i_a      (OP_A),
        .i_b_sign (OP_B[7]),
        .i_exce   (FP_EXCE),
        .o_result (w_special)
    );

    // r_cnt counts completed WAIT cycles, so the last allowed cycle sees TIMEOUT_CYCLES-1.
    always_comb begin
        w_timeout = r_cnt == CW'(TIMEOUT_CYCLES - 1);
        w_fire    = r_state == _ST_HOLD && OUT_READY;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= _ST_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= 8'h00;
            r_exce   <= _NO_EXCE;
            r_sticky <= '0;
        end else begin
            case (r_state)
                _ST_IDLE: if (IN_VALID) begin
                    r_op <= FP_OPERATION;
                    r_a  <= OP_A;
                    r_b  <= OP_B;
                    if (OP_IS_EXCEPTION) begin
                        r_result <= w_special;
                        r_exce   <= FP_EXCE;
                        r_state  <= _ST_HOLD;
                    end else begin
                        r_state <= _ST_ISSUE;
                    end
                end
                _ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= _ST_WAIT;
                end
                _ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (CORE_DONE) begin
                        r_result <= CORE_RESULT;
                        r_exce   <= _NO_EXCE;
                        r_state  <= _ST_HOLD;
                    end else if (w_timeout) begin
                        r_result <= _QNAN;
                        r_exce   <= _CORE_TO_EXCE;
                        r_state  <= _ST_HOLD;
                    end
                end
                _ST_HOLD: if (OUT_READY) r_state <= _ST_IDLE;
                default: r_state <= _ST_IDLE;
            endcase
            // A clear coinciding with a handshake still records the new flag.
            if (w_fire)
                r_sticky <= (STICKY_CLR ? 4'b0000 : r_sticky) | sticky_flag(r_exce);
            else if (STICKY_CLR)
                r_sticky <= '0;
        end
    end

    always_comb begin
        IN_READY     = r_state == _ST_IDLE;
        CORE_START   = r_state == _ST_ISSUE;
        OUT_VALID    = r_state == _ST_HOLD;
        CORE_OP      = r_op;
        CORE_A       = r_a;
        CORE_B       = r_b;
        RESULT       = r_result;
        RESULT_EXCE  = r_exce;
        STICKY_FLAGS = r_sticky;
    end

endmodule
